// File: rtl/apb_master_arbiter_if.sv
// APB bus bundle between apb_master_arbiter (master side) and the two slaves it selects.
interface apb_master_arbiter_if #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 8
);
    logic              PSEL1;
    logic              PSEL2;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-2:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        output PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_master_arbiter.sv
// Round-robin sharing of one APB master port between two requesters, address MSB picks PSEL1/PSEL2.
// Optional ACCESS-phase timeout enabled by defining APB_ARB_TIMEOUT_EN.
module apb_master_arbiter #(
    parameter int unsigned ADDR_W         = 9,
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              req0,
    input  logic              req1,
    input  logic              wr0,
    input  logic              wr1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              err0,
    output logic              err1,
    apb_master_arbiter_if.master apb
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    logic [1:0]        state;
    logic              owner;       // 1 = req1 owns the transfer in flight
    logic              last_gnt;    // 1 = most recent grant went to req1
    logic              eff0;
    logic              eff1;
    logic              pick1;
    logic              start;
    logic              finish;
    logic              timeout_hit;

    logic              win_wr;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

    logic              psel1_q;
    logic              psel2_q;
    logic              penable_q;
    logic              pwrite_q;
    logic [ADDR_W-2:0] paddr_q;
    logic [DATA_W-1:0] pwdata_q;

    // A requester still seeing its own done pulse is masked so it cannot be re-granted.
    assign eff0 = req0 & ~done0;
    assign eff1 = req1 & ~done1;

    always_comb begin
        pick1     = eff1 & (~eff0 | ~last_gnt);
        win_wr    = pick1 ? wr1    : wr0;
        win_addr  = pick1 ? addr1  : addr0;
        win_wdata = pick1 ? wdata1 : wdata0;
    end

    assign start  = (state == ST_IDLE) & (eff0 | eff1);
    assign finish = (state == ST_ACCESS) & (apb.PREADY | timeout_hit);

`ifdef APB_ARB_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TW-1:0] wait_cnt;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            wait_cnt <= '0;
        end else if ((state == ST_ACCESS) && !apb.PREADY) begin
            wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    // Fires on the edge that would be the TIMEOUT_CYCLES-th consecutive stall; PREADY there wins.
    assign timeout_hit = (state == ST_ACCESS) && !apb.PREADY &&
                         (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
`endif

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state     <= ST_IDLE;
            owner     <= 1'b0;
            last_gnt  <= 1'b1;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            psel1_q   <= 1'b0;
            psel2_q   <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_SETUP;
                        owner    <= pick1;
                        last_gnt <= pick1;
                        gnt0     <= ~pick1;
                        gnt1     <= pick1;
                        psel1_q  <= ~win_addr[ADDR_W-1];
                        psel2_q  <= win_addr[ADDR_W-1];
                        pwrite_q <= win_wr;
                        paddr_q  <= win_addr[ADDR_W-2:0];
                        pwdata_q <= win_wdata;
                    end
                end
                ST_SETUP: begin
                    state     <= ST_ACCESS;
                    penable_q <= 1'b1;
                end
                ST_ACCESS: begin
                    if (finish) begin
                        state     <= ST_IDLE;
                        gnt0      <= 1'b0;
                        gnt1      <= 1'b0;
                        psel1_q   <= 1'b0;
                        psel2_q   <= 1'b0;
                        penable_q <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    gnt0      <= 1'b0;
                    gnt1      <= 1'b0;
                    psel1_q   <= 1'b0;
                    psel2_q   <= 1'b0;
                    penable_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            done0  <= 1'b0;
            done1  <= 1'b0;
            err0   <= 1'b0;
            err1   <= 1'b0;
            rdata0 <= '0;
            rdata1 <= '0;
        end else begin
            done0 <= finish & ~owner;
            done1 <= finish & owner;
            if (finish && !owner) begin
                err0 <= timeout_hit | apb.PSLVERR;
                if (timeout_hit) begin
                    rdata0 <= '0;
                end else if (!pwrite_q) begin
                    rdata0 <= apb.PRDATA;
                end
            end
            if (finish && owner) begin
                err1 <= timeout_hit | apb.PSLVERR;
                if (timeout_hit) begin
                    rdata1 <= '0;
                end else if (!pwrite_q) begin
                    rdata1 <= apb.PRDATA;
                end
            end
        end
    end

    assign apb.PSEL1   = psel1_q;
    assign apb.PSEL2   = psel2_q;
    assign apb.PENABLE = penable_q;
    assign apb.PWRITE  = pwrite_q;
    assign apb.PADDR   = paddr_q;
    assign apb.PWDATA  = pwdata_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter; timeout scenario runs when APB_ARB_TIMEOUT_EN is defined.
module tb_apb_master_arbiter;

    logic       PCLK;
    logic       PRESET;
    logic       req0, req1, wr0, wr1;
    logic [8:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       gnt0, gnt1, done0, done1, err0, err1;
    logic [7:0] rdata0, rdata1;

    int checks;
    int failures;

    apb_master_arbiter_if #(.ADDR_W(9), .DATA_W(8)) apb ();

    apb_master_arbiter #(
        .ADDR_W(9),
        .DATA_W(8),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .req0   (req0),
        .req1   (req1),
        .wr0    (wr0),
        .wr1    (wr1),
        .addr0  (addr0),
        .addr1  (addr1),
        .wdata0 (wdata0),
        .wdata1 (wdata1),
        .gnt0   (gnt0),
        .gnt1   (gnt1),
        .done0  (done0),
        .done1  (done1),
        .rdata0 (rdata0),
        .rdata1 (rdata1),
        .err0   (err0),
        .err1   (err1),
        .apb    (apb)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        PRESET = 1'b1;
        req0 = 1'b0; req1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        apb.PRDATA = 8'h00; apb.PREADY = 1'b1; apb.PSLVERR = 1'b0;

        tick();
        tick();
        check1("rst_psel1", apb.PSEL1, 1'b0);
        check1("rst_psel2", apb.PSEL2, 1'b0);
        check1("rst_penable", apb.PENABLE, 1'b0);
        check1("rst_gnt0", gnt0, 1'b0);
        check1("rst_gnt1", gnt1, 1'b0);
        check1("rst_done0", done0, 1'b0);
        check8("rst_paddr", apb.PADDR, 8'h00);
        check8("rst_rdata1", rdata1, 8'h00);
        PRESET = 1'b0;

        // Test 1: req0 write to slave 1, zero wait states
        tick();
        req0 = 1'b1; wr0 = 1'b1; addr0 = 9'h003; wdata0 = 8'h06;
        tick();
        check1("t1_setup_psel1", apb.PSEL1, 1'b1);
        check1("t1_setup_psel2", apb.PSEL2, 1'b0);
        check1("t1_setup_penable", apb.PENABLE, 1'b0);
        check1("t1_setup_gnt0", gnt0, 1'b1);
        check1("t1_setup_pwrite", apb.PWRITE, 1'b1);
        check8("t1_setup_paddr", apb.PADDR, 8'h03);
        check8("t1_setup_pwdata", apb.PWDATA, 8'h06);
        tick();
        check1("t1_access_penable", apb.PENABLE, 1'b1);
        check1("t1_access_done0", done0, 1'b0);
        tick();
        check1("t1_done0", done0, 1'b1);
        check1("t1_err0", err0, 1'b0);
        check1("t1_end_psel1", apb.PSEL1, 1'b0);
        check1("t1_end_penable", apb.PENABLE, 1'b0);
        check1("t1_end_gnt0", gnt0, 1'b0);
        req0 = 1'b0;
        tick();
        check1("t1_done0_pulse", done0, 1'b0);

        // Test 2: req1 read from slave 2 with two wait states
        req1 = 1'b1; wr1 = 1'b0; addr1 = 9'h105; apb.PREADY = 1'b0;
        tick();
        check1("t2_setup_psel2", apb.PSEL2, 1'b1);
        check1("t2_setup_psel1", apb.PSEL1, 1'b0);
        check1("t2_setup_gnt1", gnt1, 1'b1);
        check1("t2_setup_pwrite", apb.PWRITE, 1'b0);
        check8("t2_setup_paddr", apb.PADDR, 8'h05);
        tick();
        check1("t2_access_penable", apb.PENABLE, 1'b1);
        tick();
        check1("t2_wait1_done1", done1, 1'b0);
        check1("t2_wait1_psel2", apb.PSEL2, 1'b1);
        tick();
        check1("t2_wait2_done1", done1, 1'b0);
        apb.PREADY = 1'b1; apb.PRDATA = 8'h05;
        tick();
        check1("t2_done1", done1, 1'b1);
        check8("t2_rdata1", rdata1, 8'h05);
        check1("t2_err1", err1, 1'b0);
        check1("t2_end_psel2", apb.PSEL2, 1'b0);
        check8("t2_idle_paddr_hold", apb.PADDR, 8'h05);
        check8("t2_rdata0_untouched", rdata0, 8'h00);
        req1 = 1'b0;
        tick();
        check1("t2_done1_pulse", done1, 1'b0);

        // Test 3: both requesting continuously from reset -> 0,1,0,1
        PRESET = 1'b1;
        tick();
        PRESET = 1'b0;
        req0 = 1'b1; wr0 = 1'b1; addr0 = 9'h012; wdata0 = 8'hA1;
        req1 = 1'b1; wr1 = 1'b0; addr1 = 9'h120;
        apb.PREADY = 1'b1; apb.PRDATA = 8'h3C;
        for (int t = 0; t < 4; t++) begin
            logic o;
            o = ((t % 2) == 1);
            tick();
            check1("t3_setup_gnt0", gnt0, ~o);
            check1("t3_setup_gnt1", gnt1, o);
            check1("t3_setup_psel1", apb.PSEL1, ~o);
            check1("t3_setup_psel2", apb.PSEL2, o);
            check1("t3_setup_penable", apb.PENABLE, 1'b0);
            tick();
            check1("t3_access_penable", apb.PENABLE, 1'b1);
            tick();
            check1("t3_done0", done0, ~o);
            check1("t3_done1", done1, o);
            check1("t3_idle_gnt0", gnt0, 1'b0);
            check1("t3_idle_gnt1", gnt1, 1'b0);
            check1("t3_idle_penable", apb.PENABLE, 1'b0);
            if (o) check8("t3_rdata1", rdata1, 8'h3C);
            else   check8("t3_rdata0_write", rdata0, 8'h00);
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();
        check1("t3_quiet_psel1", apb.PSEL1, 1'b0);
        check1("t3_quiet_psel2", apb.PSEL2, 1'b0);

        // Test 4: slave error, then a clean write clears err1
        req1 = 1'b1; wr1 = 1'b0; addr1 = 9'h10E;
        apb.PSLVERR = 1'b1; apb.PRDATA = 8'h77;
        tick();
        check1("t4_setup_psel2", apb.PSEL2, 1'b1);
        check8("t4_setup_paddr", apb.PADDR, 8'h0E);
        tick();
        tick();
        check1("t4_done1", done1, 1'b1);
        check1("t4_err1", err1, 1'b1);
        check8("t4_rdata1", rdata1, 8'h77);
        req1 = 1'b0; apb.PSLVERR = 1'b0;
        tick();
        req1 = 1'b1; wr1 = 1'b1; wdata1 = 8'h55;
        tick();
        check8("t4_clean_pwdata", apb.PWDATA, 8'h55);
        check1("t4_clean_pwrite", apb.PWRITE, 1'b1);
        tick();
        tick();
        check1("t4_clean_done1", done1, 1'b1);
        check1("t4_clean_err1", err1, 1'b0);
        check8("t4_write_keeps_rdata1", rdata1, 8'h77);
        req1 = 1'b0;
        tick();

        // Test 5: reset asserted during ACCESS aborts the transfer
        req0 = 1'b1; wr0 = 1'b0; addr0 = 9'h033; apb.PREADY = 1'b0;
        tick();
        tick();
        check1("t5_access_penable", apb.PENABLE, 1'b1);
        PRESET = 1'b1;
        #1;
        check1("t5_rst_psel1", apb.PSEL1, 1'b0);
        check1("t5_rst_penable", apb.PENABLE, 1'b0);
        check1("t5_rst_gnt0", gnt0, 1'b0);
        tick();
        check1("t5_rst_no_done0", done0, 1'b0);
        PRESET = 1'b0; apb.PREADY = 1'b1; apb.PRDATA = 8'h9D;
        tick();
        check1("t5_retry_gnt0", gnt0, 1'b1);
        check8("t5_retry_paddr", apb.PADDR, 8'h33);
        tick();
        tick();
        check1("t5_retry_done0", done0, 1'b1);
        check8("t5_retry_rdata0", rdata0, 8'h9D);
        check1("t5_retry_err0", err0, 1'b0);
        req0 = 1'b0;
        tick();

`ifdef APB_ARB_TIMEOUT_EN
        // Test 6: PREADY never arrives, timeout ends the transfer with an error
        req0 = 1'b1; wr0 = 1'b1; addr0 = 9'h044; wdata0 = 8'hC3; apb.PREADY = 1'b0;
        tick();
        tick();
        check1("t6_access_penable", apb.PENABLE, 1'b1);
        for (int i = 1; i < 16; i++) begin
            tick();
            check1("t6_wait_done0", done0, 1'b0);
            check1("t6_wait_penable", apb.PENABLE, 1'b1);
        end
        tick();
        check1("t6_done0", done0, 1'b1);
        check1("t6_err0", err0, 1'b1);
        check8("t6_rdata0", rdata0, 8'h00);
        req0 = 1'b0;
        tick();
        check1("t6_idle_psel1", apb.PSEL1, 1'b0);
        check1("t6_idle_penable", apb.PENABLE, 1'b0);
        check1("t6_idle_gnt0", gnt0, 1'b0);
        check1("t6_idle_done0", done0, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
